uart_frame_rx: RTL and testbench

Framing stage between the UART receiver byte output and the image buffer write port. It hunts for a sync byte and reads a 16-bit big-endian payload length. Payload bytes are written sequentially into image memory, then an XOR checksum byte is verified. One frame_done pulse marks a good image; frame_err plus err_code mark a rejected one. A good frame starts the processing FSM, replacing the bare "first rx_done" trigger.

---
 rtl/uart_frame_rx_pkg.sv | 19 +
 rtl/uart_frame_rx_if.sv | 30 +++
 rtl/uart_frame_rx_timeout_ctr.sv | 27 ++
 rtl/uart_frame_rx.sv | 137 +++++++++++++
 tb/tb_uart_frame_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the UART framing stage: FSM state encoding,
// error codes reported on err_code, and the default frame start marker.
package uart_frame_rx_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-in / image-write-out bundle of the framing stage. Member prefixes are
// from the framer's point of view: i_ are driven into it, o_ come out of it.
interface uart_frame_rx_if #(
  parameter int ADDR_W = 10
);

  logic [7:0]        i_rx_data;
  logic              i_rx_done;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data;
  logic              o_frame_done;
  logic [15:0]       o_frame_len;
  logic              o_frame_err;
  logic [1:0]        o_err_code;
  logic              o_busy;

  modport master (
    output i_rx_data, i_rx_done,
    input  o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_frame_len,
    input  o_frame_err, o_err_code, o_busy
  );

  modport slave (
    input  i_rx_data, i_rx_done,
    output o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_frame_len,
    output o_frame_err, o_err_code, o_busy
  );

endinterface

// File: rtl/uart_frame_rx_timeout_ctr.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYC-1 idle cycles have been counted.
module frame_timeout_ctr #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = (r_count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser between the UART byte receiver and the image buffer: hunts for
// the sync byte, reads a big-endian length, writes the payload, checks the XOR.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter int         MAX_LEN     = 1024,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            rst,
  uart_frame_rx_if.slave  io_bus
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [7:0]        r_acc;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_frame_done;
  logic [15:0]       r_frame_len;
  logic              r_frame_err;
  logic [1:0]        r_err_code;
  logic              r_busy;

  logic [15:0]       w_len_new;
  logic              w_tmo_clear;
  logic              w_expire;

  assign w_len_new   = {r_len[15:8], io_bus.i_rx_data};
  // Idle time only counts inside a frame; any accepted byte restarts it.
  assign w_tmo_clear = io_bus.i_rx_done || !r_busy;

  frame_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmo_clear),
    .i_enable (r_busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_len        <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_len  <= '0;
      r_frame_err  <= 1'b0;
      r_err_code   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (io_bus.i_rx_done) begin
        unique case (r_state)
          HUNT: begin
            if (io_bus.i_rx_data == SYNC_BYTE) begin
              r_state <= LEN_HI;
              r_busy  <= 1'b1;
            end
          end
          LEN_HI: begin
            r_len   <= {io_bus.i_rx_data, r_len[7:0]};
            r_state <= LEN_LO;
          end
          LEN_LO: begin
            r_len <= w_len_new;
            if (w_len_new == 16'd0 || w_len_new > MAX_LEN_W) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_LEN;
              r_state     <= HUNT;
              r_busy      <= 1'b0;
            end else begin
              r_cnt   <= '0;
              r_acc   <= '0;
              r_state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cnt[ADDR_W-1:0];
            r_wr_data <= io_bus.i_rx_data;
            r_acc     <= r_acc ^ io_bus.i_rx_data;
            r_cnt     <= r_cnt + 16'd1;
            if (r_cnt == r_len - 16'd1) begin
              r_state <= CHECK;
            end
          end
          CHECK: begin
            if (io_bus.i_rx_data == r_acc) begin
              r_frame_done <= 1'b1;
              r_frame_len  <= r_len;
            end else begin
              r_frame_err  <= 1'b1;
              r_err_code   <= ERR_CHK;
            end
            r_state <= HUNT;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= HUNT;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (w_expire && r_busy) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_TMO;
        r_state     <= HUNT;
        r_busy      <= 1'b0;
      end
    end
  end

  assign io_bus.o_wr_en      = r_wr_en;
  assign io_bus.o_wr_addr    = r_wr_addr;
  assign io_bus.o_wr_data    = r_wr_data;
  assign io_bus.o_frame_done = r_frame_done;
  assign io_bus.o_frame_len  = r_frame_len;
  assign io_bus.o_frame_err  = r_frame_err;
  assign io_bus.o_err_code   = r_err_code;
  assign io_bus.o_busy       = r_busy;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: frames are described at frame level
// and their expected writes/pulses (with cycle stamps) are compared to a log.
module tb_uart_frame_rx;
  import uart_frame_rx_pkg::*;

  localparam int MAX_LEN = 1024;
  localparam int TMO     = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Event word: {kind, a, b, cycle}; kind 0=write(addr,data) 1=done(len) 2=err(code)
  logic [63:0] expQ[$];
  logic [63:0] obsQ[$];

  uart_frame_rx_if #(.ADDR_W(10)) bus ();

  uart_frame_rx #(
    .ADDR_W      (10),
    .MAX_LEN     (MAX_LEN),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mkEv(input int kind, input int a, input int b, input int c);
    return {8'(kind), 16'(a), 8'(b), 32'(c)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are logged half a cycle after the edge that produced them.
  always @(negedge clk) begin
    if (bus.o_wr_en === 1'b1)
      obsQ.push_back(mkEv(0, int'(bus.o_wr_addr), int'(bus.o_wr_data), cyc));
    if (bus.o_frame_done === 1'b1)
      obsQ.push_back(mkEv(1, int'(bus.o_frame_len), 0, cyc));
    if (bus.o_frame_err === 1'b1)
      obsQ.push_back(mkEv(2, int'(bus.o_err_code), 0, cyc));
    if (bus.o_frame_done === 1'b1 || bus.o_frame_err === 1'b1)
      checkOutput("doneErrExclusive", 64'(bus.o_frame_done & bus.o_frame_err), 64'd0);
  end

  function automatic int pickGap(input int gapSel);
    int r;
    if (gapSel >= 0) return gapSel;
    r = $urandom_range(0, 15);
    if (r == 0) return TMO - 1;
    if (r == 1) return TMO - 2;
    return $urandom_range(0, 3);
  endfunction

  // Idles 'gap' cycles, then presents one byte; stamp is the sampling edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap, output int stamp);
    bus.i_rx_done = 1'b0;
    repeat (gap) @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    stamp = cyc + 1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic checkZeros(input string tag);
    checkOutput({tag, ".wr_en"},      64'(bus.o_wr_en),      64'd0);
    checkOutput({tag, ".wr_addr"},    64'(bus.o_wr_addr),    64'd0);
    checkOutput({tag, ".wr_data"},    64'(bus.o_wr_data),    64'd0);
    checkOutput({tag, ".frame_done"}, 64'(bus.o_frame_done), 64'd0);
    checkOutput({tag, ".frame_len"},  64'(bus.o_frame_len),  64'd0);
    checkOutput({tag, ".frame_err"},  64'(bus.o_frame_err),  64'd0);
    checkOutput({tag, ".err_code"},   64'(bus.o_err_code),   64'd0);
    checkOutput({tag, ".busy"},       64'(bus.o_busy),       64'd0);
  endtask

  // Sends garbage, then one frame (optionally cut short after 'cut' bytes),
  // and records the outcome the frame format dictates.
  task automatic sendFrame(input logic [7:0] garb[$], input logic [15:0] len,
                           input logic [7:0] pay[$], input logic [7:0] chk,
                           input int cut, input int gapSel, input bit resetAfter);
    logic [7:0] bytes[$];
    logic [7:0] x;
    int stamp;
    int nSend;
    bit lenBad;
    stamp  = 0;
    lenBad = (len == 16'd0) || (int'(len) > MAX_LEN);
    foreach (garb[i]) applyStimulus(garb[i], pickGap(gapSel), stamp);
    bytes.delete();
    bytes.push_back(8'hA5);
    bytes.push_back(len[15:8]);
    bytes.push_back(len[7:0]);
    x = 8'h00;
    if (!lenBad) begin
      foreach (pay[i]) begin
        bytes.push_back(pay[i]);
        x ^= pay[i];
      end
      bytes.push_back(chk);
    end
    nSend = (cut > 0 && cut < bytes.size()) ? cut : bytes.size();
    for (int i = 0; i < nSend; i++) begin
      applyStimulus(bytes[i], pickGap(gapSel), stamp);
      if (i == 0) checkOutput("busyInFrame", 64'(bus.o_busy), 64'd1);
      if (!lenBad && i >= 3 && i < 3 + int'(len))
        expQ.push_back(mkEv(0, i - 3, int'(bytes[i]), stamp));
    end
    if (resetAfter) begin
      rst = 1'b1;
      @(negedge clk);
      checkZeros("midFrameReset");
      rst = 1'b0;
    end else begin
      if (lenBad) begin
        expQ.push_back(mkEv(2, 1, 0, stamp));
      end else if (nSend == bytes.size()) begin
        if (chk == x) expQ.push_back(mkEv(1, int'(len), 0, stamp));
        else          expQ.push_back(mkEv(2, 2, 0, stamp));
      end else begin
        expQ.push_back(mkEv(2, 3, 0, stamp + TMO));
        repeat (TMO + 5) @(negedge clk);
      end
      checkOutput("busyAfterFrame", 64'(bus.o_busy), 64'd0);
    end
  endtask

  initial begin
    logic [7:0] g[$];
    logic [7:0] p[$];
    logic [7:0] b;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    repeat (3) @(negedge clk);
    checkZeros("reset");
    rst = 1'b0;
    @(negedge clk);

    g.delete();
    p = {8'h10, 8'h20, 8'h30, 8'h40};
    sendFrame(g, 16'd4, p, 8'h40, 0, 1, 1'b0);
    sendFrame(g, 16'd4, p, 8'h50, 0, 0, 1'b0);
    p = {8'hFF, 8'h01};
    sendFrame(g, 16'd2, p, 8'h00, 0, 2, 1'b0);
    p.delete();
    sendFrame(g, 16'd0, p, 8'h00, 0, 0, 1'b0);
    sendFrame(g, 16'd1025, p, 8'h00, 0, 1, 1'b0);
    p = {8'h11, 8'h22, 8'h33};
    sendFrame(g, 16'd3, p, 8'h00, 4, 0, 1'b0);
    p = {8'h55, 8'h66};
    sendFrame(g, 16'd2, p, 8'h33, 0, TMO - 2, 1'b0);
    sendFrame(g, 16'd2, p, 8'h33, 0, TMO - 1, 1'b0);
    g = {8'h00, 8'h33};
    p = {8'h7E};
    sendFrame(g, 16'd1, p, 8'h7E, 0, 0, 1'b0);
    g.delete();
    p = {8'h3C};
    sendFrame(g, 16'd1, p, 8'h3C, 0, 0, 1'b0);
    p.delete();
    b = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      p.push_back(8'(i * 7 + 3));
      b ^= 8'(i * 7 + 3);
    end
    sendFrame(g, 16'(MAX_LEN), p, b, 0, 0, 1'b0);
    p = {8'h01, 8'h02, 8'h03, 8'h04};
    sendFrame(g, 16'd4, p, 8'h04, 5, 0, 1'b1);
    sendFrame(g, 16'd4, p, 8'h04, 0, 0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int kind;
      int len;
      int cut;
      logic [7:0] chk;
      logic [7:0] x;
      g.delete();
      p.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        g.push_back(b);
      end
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 12);
      x    = 8'h00;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        p.push_back(b);
        x ^= b;
      end
      cut = 0;
      chk = x;
      case (kind)
        5:       chk = x ^ 8'($urandom_range(1, 255));
        6:       begin len = 0; p.delete(); end
        7:       begin len = $urandom_range(MAX_LEN + 1, 65535); p.delete(); end
        8, 9:    cut = $urandom_range(1, 3 + len);
        default: ;
      endcase
      sendFrame(g, 16'(len), p, chk, cut, -1, 1'b0);
    end

    repeat (10) @(negedge clk);
    checkOutput("eventCount", 64'(obsQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      checkOutput($sformatf("event%0d", i), obsQ[i], expQ[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
